// File: rtl/mips_mem_pkg.sv
// Shared widths and enums for the memory-port arbiter.
package mips_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and load/store; MEM wins by default.
// Optional ARB_STARVE_GUARD_EN forces an IF grant after STARVE_LIMIT consecutive IF losses.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_q, store_d;
  logic             force_if;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_if = (starve_q == STARVE_W'(STARVE_LIMIT));

  // Counts IF losses in IDLE; cannot pass the limit since reaching it makes IF win.
  always_comb begin
    starve_d = starve_q;
    if (!rst && state_q == ARB_IDLE) begin
      if (if_gnt) begin
        starve_d = '0;
      end else if (if_req && mem_gnt) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic starve_limit_unused;

  assign starve_limit_unused = ^STARVE_LIMIT;
  assign force_if            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    store_d    = store_q;
    if_gnt     = 1'b0;
    mem_gnt    = 1'b0;
    if_rvalid  = 1'b0;
    mem_rvalid = 1'b0;
    if_rdata   = '0;
    mem_rdata  = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (mem_req && !(if_req && force_if)) begin
            mem_gnt   = 1'b1;
            ram_en    = 1'b1;
            ram_we    = mem_we;
            ram_addr  = mem_addr;
            ram_wdata = mem_wdata;
            owner_d   = OWN_MEM;
            store_d   = mem_we;
            cnt_d     = CNT_W'(MEM_LATENCY - 1);
            state_d   = ARB_WAIT;
          end else if (if_req) begin
            if_gnt   = 1'b1;
            ram_en   = 1'b1;
            ram_addr = if_addr;
            owner_d  = OWN_IF;
            store_d  = 1'b0;
            cnt_d    = CNT_W'(MEM_LATENCY - 1);
            state_d  = ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // Response cycle: no new grant until the port is back in IDLE.
          if (cnt_q == '0) begin
            state_d = ARB_IDLE;
            if (owner_q == OWN_IF) begin
              if_rvalid = 1'b1;
              if_rdata  = ram_rdata;
            end else begin
              mem_rvalid = 1'b1;
              mem_rdata  = store_q ? '0 : ram_rdata;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
    stall_if  = if_req & ~if_rvalid;
    stall_mem = mem_req & ~mem_rvalid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter (MEM_LATENCY=2 and MEM_LATENCY=1 instances).
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] ram_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        stall_if;
    logic        stall_mem;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] ram_rdata;

  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, ram_en, ram_we, stall_if, stall_mem;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_gnt1, if_rvalid1, mem_gnt1, mem_rvalid1, ram_en1, ram_we1, stall_if1, stall_mem1;
  logic [31:0] if_rdata1, mem_rdata1, ram_addr1, ram_wdata1;

  int vectors;
  int miscompares;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt1), .mem_rvalid(mem_rvalid1), .mem_rdata(mem_rdata1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata),
    .stall_if(stall_if1), .stall_mem(stall_mem1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk_in(logic r, logic ir, logic [31:0] ia, logic mr, logic mw,
                                logic [31:0] ma, logic [31:0] md, logic [31:0] rd);
    in_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.mem_req = mr; v.mem_we = mw;
    v.mem_addr = ma; v.mem_wdata = md; v.ram_rdata = rd;
    return v;
  endfunction

  function automatic out_t mk_out(logic ig, logic iv, logic [31:0] id, logic mg, logic mv,
                                  logic [31:0] md, logic en, logic we, logic [31:0] ra,
                                  logic [31:0] rw, logic si, logic sm);
    out_t o;
    o.if_gnt = ig; o.if_rvalid = iv; o.if_rdata = id; o.mem_gnt = mg; o.mem_rvalid = mv;
    o.mem_rdata = md; o.ram_en = en; o.ram_we = we; o.ram_addr = ra; o.ram_wdata = rw;
    o.stall_if = si; o.stall_mem = sm;
    return o;
  endfunction

  task automatic apply(input in_t v);
    rst = v.rst; if_req = v.if_req; if_addr = v.if_addr; mem_req = v.mem_req;
    mem_we = v.mem_we; mem_addr = v.mem_addr; mem_wdata = v.mem_wdata; ram_rdata = v.ram_rdata;
  endtask

  function automatic out_t sample0();
    return mk_out(if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
                  ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem);
  endfunction

  function automatic out_t sample1();
    return mk_out(if_gnt1, if_rvalid1, if_rdata1, mem_gnt1, mem_rvalid1, mem_rdata1,
                  ram_en1, ram_we1, ram_addr1, ram_wdata1, stall_if1, stall_mem1);
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  localparam int NV = 25;
  vec_t vecs[NV];

  initial begin
    int if_cnt;
    int mem_cnt;
    int exp_if;
    int exp_mem;
    logic odd;
    vectors     = 0;
    miscompares = 0;
    apply(mk_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0));

    // Reset gating
    vecs[0]  = '{mk_in(1, 1, 32'h40, 1, 0, 32'h200, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
    vecs[1]  = '{mk_in(1, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // IF-only fetch, 2-cycle latency
    vecs[2]  = '{mk_in(0, 1, 32'h40, 0, 0, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 1, 0, 32'h40, 0, 1, 0)};
    vecs[3]  = '{mk_in(0, 1, 32'h40, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[4]  = '{mk_in(0, 1, 32'h40, 0, 0, 0, 0, 32'h2402000A),
                 mk_out(0, 1, 32'h2402000A, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[5]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 32'h2402000A), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // Store
    vecs[6]  = '{mk_in(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0),
                 mk_out(0, 0, 0, 1, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 1)};
    vecs[7]  = '{mk_in(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    vecs[8]  = '{mk_in(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 32'h12345678),
                 mk_out(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // Both request: MEM first, IF granted at T+3, IF data at T+5
    vecs[10] = '{mk_in(0, 1, 32'h44, 1, 0, 32'h200, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 1, 0, 32'h200, 0, 1, 1)};
    vecs[11] = '{mk_in(0, 1, 32'h44, 1, 0, 32'h200, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
    vecs[12] = '{mk_in(0, 1, 32'h44, 1, 0, 32'h200, 0, 32'hCAFEF00D),
                 mk_out(0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0, 1, 0)};
    vecs[13] = '{mk_in(0, 1, 32'h44, 0, 0, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 1, 0, 32'h44, 0, 1, 0)};
    vecs[14] = '{mk_in(0, 1, 32'h44, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[15] = '{mk_in(0, 1, 32'h44, 0, 0, 0, 0, 32'h0BADC0DE),
                 mk_out(0, 1, 32'h0BADC0DE, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // Held req becomes a new request; reset kills it in flight
    vecs[16] = '{mk_in(0, 1, 32'h44, 0, 0, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 1, 0, 32'h44, 0, 1, 0)};
    vecs[17] = '{mk_in(1, 1, 32'h44, 0, 0, 0, 0, 32'h77777777), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    vecs[18] = '{mk_in(0, 1, 32'h48, 0, 0, 0, 0, 0), mk_out(1, 0, 0, 0, 0, 0, 1, 0, 32'h48, 0, 1, 0)};
    // Req dropped after grant still completes
    vecs[19] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vecs[20] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 32'h11112222),
                 mk_out(0, 1, 32'h11112222, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    // IF arrives during WAIT, withdraws before any grant
    vecs[21] = '{mk_in(0, 0, 0, 1, 0, 32'h300, 0, 0), mk_out(0, 0, 0, 1, 0, 0, 1, 0, 32'h300, 0, 0, 1)};
    vecs[22] = '{mk_in(0, 1, 32'h4C, 1, 0, 32'h300, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)};
    vecs[23] = '{mk_in(0, 0, 32'h4C, 1, 0, 32'h300, 0, 32'h33334444),
                 mk_out(0, 0, 0, 0, 1, 32'h33334444, 0, 0, 0, 0, 0, 0)};
    vecs[24] = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0), mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vecs[i].in);
      #2;
      check_out($sformatf("vec%0d", i), sample0(), vecs[i].exp);
    end

    // Continuous contention: strict priority vs. starvation guard
    @(negedge clk);
    apply(mk_in(1, 0, 0, 0, 0, 0, 0, 0));
    if_cnt  = 0;
    mem_cnt = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      apply(mk_in(0, 1, 32'h80, 1, 0, 32'h400, 0, 32'h5A5A5A5A));
      #2;
      if (if_gnt) if_cnt++;
      if (mem_gnt) mem_cnt++;
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_if  = 1;
    exp_mem = 5;
`else
    exp_if  = 0;
    exp_mem = 6;
`endif
    check_int("contend_if_gnts", if_cnt, exp_if);
    check_int("contend_mem_gnts", mem_cnt, exp_mem);

    // MEM_LATENCY=1: grant every other cycle, data the cycle after
    @(negedge clk);
    apply(mk_in(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      apply(mk_in(0, 1, 32'h80, 0, 0, 0, 0, 32'hA0000000 + 32'(k)));
      #2;
      odd = 1'(k % 2);
      check_out($sformatf("lat1_cyc%0d", k), sample1(),
                mk_out(~odd, odd, odd ? 32'hA0000000 + 32'(k) : 32'h0, 0, 0, 0,
                       ~odd, 0, odd ? 32'h0 : 32'h80, 0, ~odd, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
